// File: rtl/hazard_unit_pkg.sv
// Shared processor types for the hazard controller: in-flight entry record, register/operand typedefs, defaults.
// The entry latency field exists only when HAZARD_FWD_EN is defined.
package hazard_unit_pkg;

    localparam int DEFAULT_DBITS          = 32;
    localparam int DEFAULT_REG_INDEX_BITS = 4;
    localparam int DEFAULT_DEPTH          = 3;
    localparam int DEFAULT_LOAD_LAT       = 2;

    // Entries carry the widest supported register number; narrower cores zero-extend.
    localparam int MAX_REG_INDEX_BITS = 8;
    localparam int LAT_BITS           = 4;

    typedef logic [MAX_REG_INDEX_BITS-1:0] reg_idx_t;
    typedef logic [DEFAULT_DBITS-1:0]      operand_t;
    typedef logic [LAT_BITS-1:0]           lat_t;

    typedef struct packed {
        logic     wr;
        reg_idx_t rd;
`ifdef HAZARD_FWD_EN
        lat_t     lat;
`endif
    } entry_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-side bundle of the hazard controller: source/destination fields, register file and stage data in,
// forwarded operands and stall/bubble out. Purely combinational signals, no handshake.
interface hazard_unit_if
    import hazard_unit_pkg::*;
#(
    parameter int DBITS               = DEFAULT_DBITS,
    parameter int REG_INDEX_BIT_WIDTH = DEFAULT_REG_INDEX_BITS,
    parameter int DEPTH               = DEFAULT_DEPTH
);
    logic [REG_INDEX_BIT_WIDTH-1:0] dec_rs1;
    logic [REG_INDEX_BIT_WIDTH-1:0] dec_rs2;
    logic                           dec_rs1_used;
    logic                           dec_rs2_used;
    logic                           dec_wr;
    logic [REG_INDEX_BIT_WIDTH-1:0] dec_rd;
    logic                           dec_is_load;
    logic                           redirect;
    logic [DBITS-1:0]               reg_data1;
    logic [DBITS-1:0]               reg_data2;
    logic [DEPTH*DBITS-1:0]         stage_data;
    logic [DBITS-1:0]               fwd_data1;
    logic [DBITS-1:0]               fwd_data2;
    logic                           stall;
    logic                           bubble;

    modport master (
        output dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_wr, dec_rd, dec_is_load,
               redirect, reg_data1, reg_data2, stage_data,
        input  fwd_data1, fwd_data2, stall, bubble
    );

    modport slave (
        input  dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_wr, dec_rd, dec_is_load,
               redirect, reg_data1, reg_data2, stage_data,
        output fwd_data1, fwd_data2, stall, bubble
    );

endinterface

// File: rtl/hazard_operand_sel.sv
// One source operand: youngest-match scan over in-flight entries, yields operand value and not-ready flag.
// Combinational; with HAZARD_FWD_EN undefined only the writeback entry forwards, any other match is not ready.
module hazard_operand_sel
    import hazard_unit_pkg::*;
#(
    parameter int DBITS               = DEFAULT_DBITS,
    parameter int REG_INDEX_BIT_WIDTH = DEFAULT_REG_INDEX_BITS,
    parameter int DEPTH               = DEFAULT_DEPTH
) (
    input  entry_t [DEPTH-1:0]              entries,
    input  logic   [REG_INDEX_BIT_WIDTH-1:0] src,
    input  logic                            used,
    input  logic   [DBITS-1:0]              reg_data,
    input  logic   [DEPTH*DBITS-1:0]        stage_data,
    output logic   [DBITS-1:0]              operand,
    output logic                            not_ready
);

    logic             hit;
    logic             hit_rdy;
    logic [DBITS-1:0] hit_data;

    // Scan oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && entries[k].wr && (entries[k].rd == reg_idx_t'(src))) begin
                hit      = 1'b1;
`ifdef HAZARD_FWD_EN
                hit_rdy  = ((k + 1) >= int'(entries[k].lat));
`else
                hit_rdy  = (k == DEPTH - 1);
`endif
                hit_data = stage_data[k*DBITS +: DBITS];
            end
        end
    end

    always_comb begin
        operand   = reg_data;
        not_ready = 1'b0;
        if (hit) begin
            if (hit_rdy) begin
                operand = hit_data;
            end else begin
                not_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: DEPTH-entry writer shift register, operand forwarding, decode stall and bubble.
// Outputs combinational from decode/redirect/entries; entries shift each clk edge. HAZARD_FWD_EN enables full forwarding.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int DBITS               = DEFAULT_DBITS,
    parameter int REG_INDEX_BIT_WIDTH = DEFAULT_REG_INDEX_BITS,
    parameter int DEPTH               = DEFAULT_DEPTH,
    parameter int LOAD_LAT            = DEFAULT_LOAD_LAT
) (
    input  logic         clk,
    input  logic         reset_n,
    hazard_unit_if.slave hif
);

    entry_t [DEPTH-1:0] entries_q;
    entry_t [DEPTH-1:0] entries_d;
    logic               not_ready1;
    logic               not_ready2;
    logic               stall_c;
    logic               bubble_c;

    hazard_operand_sel #(
        .DBITS               (DBITS),
        .REG_INDEX_BIT_WIDTH (REG_INDEX_BIT_WIDTH),
        .DEPTH               (DEPTH)
    ) u_sel1 (
        .entries    (entries_q),
        .src        (hif.dec_rs1),
        .used       (hif.dec_rs1_used),
        .reg_data   (hif.reg_data1),
        .stage_data (hif.stage_data),
        .operand    (hif.fwd_data1),
        .not_ready  (not_ready1)
    );

    hazard_operand_sel #(
        .DBITS               (DBITS),
        .REG_INDEX_BIT_WIDTH (REG_INDEX_BIT_WIDTH),
        .DEPTH               (DEPTH)
    ) u_sel2 (
        .entries    (entries_q),
        .src        (hif.dec_rs2),
        .used       (hif.dec_rs2_used),
        .reg_data   (hif.reg_data2),
        .stage_data (hif.stage_data),
        .operand    (hif.fwd_data2),
        .not_ready  (not_ready2)
    );

    // A redirected decode instruction is dead, so its hazards must not hold the front end.
    always_comb begin
        stall_c  = (not_ready1 | not_ready2) & ~hif.redirect;
        bubble_c = stall_c | hif.redirect;
    end

    always_comb begin
        entries_d = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            entries_d[k] = entries_q[k-1];
        end
        if (!bubble_c) begin
            entries_d[0].wr  = hif.dec_wr;
            entries_d[0].rd  = reg_idx_t'(hif.dec_rd);
`ifdef HAZARD_FWD_EN
            entries_d[0].lat = hif.dec_is_load ? lat_t'(LOAD_LAT) : lat_t'(1);
`endif
        end
    end

`ifndef HAZARD_FWD_EN
    logic unused_is_load;
    assign unused_is_load = hif.dec_is_load;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    assign hif.stall  = stall_c;
    assign hif.bubble = bubble_c;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus randomized decode traffic against an instruction-history model.
// Works with or without HAZARD_FWD_EN defined.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int DBITS    = 32;
    localparam int RIB      = 4;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 2;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    hazard_unit_if #(.DBITS(DBITS), .REG_INDEX_BIT_WIDTH(RIB), .DEPTH(DEPTH)) hif ();

    hazard_unit #(
        .DBITS               (DBITS),
        .REG_INDEX_BIT_WIDTH (RIB),
        .DEPTH               (DEPTH),
        .LOAD_LAT            (LOAD_LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hif     (hif.slave)
    );

    // History of what entered the pipe, newest first; index = cycles since issue - 1.
    typedef struct { bit wr; int rd; bit ld; } rec_t;
    rec_t hist[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void op_eval(input bit used, input int src, input logic [31:0] rdat,
                                    output logic [31:0] val, output bit nr);
        val = rdat;
        nr  = 1'b0;
        if (!used) return;
        for (int a = 0; a < hist.size() && a < DEPTH; a++) begin
            if (hist[a].wr && hist[a].rd == src) begin
                int lat;
                bit rdy;
                lat = hist[a].ld ? LOAD_LAT : 1;
                rdy = FWD ? (a + 1 >= lat) : (a == DEPTH - 1);
                if (rdy) val = hif.stage_data[a*DBITS +: DBITS];
                else     nr  = 1'b1;
                return;
            end
        end
    endfunction

    task automatic compare(output bit bub_e);
        logic [31:0] f1, f2;
        bit n1, n2, st;
        op_eval(hif.dec_rs1_used, int'(hif.dec_rs1), hif.reg_data1, f1, n1);
        op_eval(hif.dec_rs2_used, int'(hif.dec_rs2), hif.reg_data2, f2, n2);
        st    = (n1 || n2) && !hif.redirect;
        bub_e = st || hif.redirect;
        chk("stall", hif.stall, st);
        chk("bubble", hif.bubble, bub_e);
        if (!n1) chk("fwd1", hif.fwd_data1, f1);
        if (!n2) chk("fwd2", hif.fwd_data2, f2);
    endtask

    task automatic cycle();
        bit   bub;
        rec_t r;
        #1;
        compare(bub);
        r = bub ? rec_t'{1'b0, 0, 1'b0} : rec_t'{hif.dec_wr, int'(hif.dec_rd), hif.dec_is_load};
        @(posedge clk);
        if (reset_n) begin
            hist.push_front(r);
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic drive(input int rs1, input bit u1, input int rs2, input bit u2,
                         input bit wr, input int rd, input bit ld, input bit redir);
        hif.dec_rs1      = rs1[RIB-1:0];
        hif.dec_rs1_used = u1;
        hif.dec_rs2      = rs2[RIB-1:0];
        hif.dec_rs2_used = u2;
        hif.dec_wr       = wr;
        hif.dec_rd       = rd[RIB-1:0];
        hif.dec_is_load  = ld;
        hif.redirect     = redir;
    endtask

    task automatic set_stage(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
        hif.stage_data = {s2, s1, s0};
    endtask

    task automatic flush();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH) cycle();
    endtask

    task automatic do_reset();
        bit b;
        reset_n = 1'b0;
        hist.delete();
        #1;
        compare(b);
        #1;
        reset_n = 1'b1;
    endtask

    // Producer writes r, dependent reads r and is held in decode while stalled.
    task automatic dep_run(input string tag, input bit ld, input int r,
                           input int exp_st, input logic [31:0] exp_val);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        drive(0, 0, 0, 0, 1, r, ld, 0);
        cycle();
        drive(r, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            if (hif.stall === 1'b0) begin
                done = 1'b1;
                chk({tag, "_val"}, hif.fwd_data1, exp_val);
            end else begin
                n++;
            end
            cycle();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stalls"}, n, exp_st);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit b;
        reset_n = 1'b0;
        drive(3, 1, 0, 0, 0, 0, 0, 0);
        hif.reg_data1 = 32'h11;
        hif.reg_data2 = 32'h22;
        set_stage(32'h0, 32'h0, 32'h0);
        #1;
        chk("rst_stall", hif.stall, 0);
        chk("rst_fwd1", hif.fwd_data1, 32'h11);
        chk("rst_bubble", hif.bubble, 0);
        hif.redirect = 1'b1;
        #1;
        chk("rst_bubble_redir", hif.bubble, 1);
        compare(b);
        hif.redirect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        #1;
        chk("r3_stall", hif.stall, 0);
        chk("r3_fwd1", hif.fwd_data1, 32'h11);
        cycle();

        set_stage(32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003);
        dep_run("alu", 1'b0, 5, FWD ? 0 : DEPTH - 1, FWD ? 32'hAAAA0001 : 32'hCCCC0003);
        flush();

        set_stage(32'h5555, 32'h1234, 32'h9999);
        dep_run("load", 1'b1, 2, FWD ? LOAD_LAT - 1 : DEPTH - 1, FWD ? 32'h1234 : 32'h9999);
        flush();

        drive(0, 0, 0, 0, 1, 4, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 4, 0, 0);
        cycle();
        set_stage(32'h7, 32'h55, 32'h9);
        drive(4, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("young_stall", hif.stall, FWD ? 0 : 1);
        chk("young_fwd", hif.fwd_data1, FWD ? 32'h7 : 32'h11);
        cycle();
        flush();

        drive(0, 0, 0, 0, 1, 2, 1, 0);
        cycle();
        drive(2, 1, 0, 0, 1, 9, 0, 1);
        #1;
        chk("redir_stall", hif.stall, 0);
        chk("redir_bubble", hif.bubble, 1);
        cycle();
        set_stage(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002);
        drive(9, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("redir_noins_stall", hif.stall, 0);
        chk("redir_noins_fwd", hif.fwd_data1, 32'h11);
        cycle();
        flush();

        drive(0, 0, 0, 0, 1, 6, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 7, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 8, 0, 0);
        cycle();
        do_reset();
        drive(6, 1, 7, 1, 0, 0, 0, 0);
        #1;
        chk("rstmid_stall", hif.stall, 0);
        chk("rstmid_fwd1", hif.fwd_data1, 32'h11);
        chk("rstmid_fwd2", hif.fwd_data2, 32'h22);
        cycle();
        flush();

        drive(0, 0, 0, 0, 1, 10, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH) cycle();
        drive(10, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("retired_stall", hif.stall, 0);
        chk("retired_fwd", hif.fwd_data1, 32'h11);
        cycle();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            drive($urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
                  $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0), $urandom_range(0, 7),
                  1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) == 0));
            hif.reg_data1 = $urandom;
            hif.reg_data2 = $urandom;
            set_stage($urandom, $urandom, $urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
